// File: rtl/scanner_run_length_if.sv
// Run-token stream between the scanner and its consumer.
// Latency: none, wires only.
// Backpressure: consumer drops iRunReady to hold the head token in place.
interface scanner_run_length_if;
  logic [4:0] oRunData;   // {eol, color, units[2:0]}
  logic       oRunValid;
  logic       iRunReady;

  modport master (
    output oRunData,
    output oRunValid,
    input  iRunReady
  );

  modport slave (
    input  oRunData,
    input  oRunValid,
    output iRunReady
  );
endinterface

// File: rtl/scanner_run_length.sv
// Barcode scanline run-length tokenizer: locks on a bar-space-bar guard, then quantises runs to module units.
// Latency: closing pixel sampled at edge N, token in FIFO and visible at edge N+1.
// Backpressure: first-word-fall-through token FIFO; tokens arriving while it is full are dropped and flagged sticky.
module scanner_run_length #(
  parameter int H_ACTIVE         = 640,
  parameter int MIN_MODULE_WIDTH = 2,
  parameter int MAX_MODULE_WIDTH = 8,
  parameter int TOL_MODULE_WIDTH = 1,
  parameter int MAX_UNITS        = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter bit POLARITY         = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iPixelSync,
  input  logic iPixelActive,
  input  logic iPixelData,
  output logic oPixelSync,
  output logic oPixelActive,
  output logic oPixelData,
  scanner_run_length_if.master run,
  output logic [$clog2(3*MAX_MODULE_WIDTH+1)-1:0] oModuleWidth3,
  output logic oLocked,
  output logic oOverflow
);

  localparam int MW3_W   = $clog2(3*MAX_MODULE_WIDTH+1);
  localparam int RUN_MAX = MAX_MODULE_WIDTH*MAX_UNITS + TOL_MODULE_WIDTH;
  // A run can never be longer than a line, so the counter need not exceed that either.
  localparam int RUN_CAP = (RUN_MAX < H_ACTIVE) ? RUN_MAX : H_ACTIVE;
  localparam int RUN_W   = $clog2(RUN_CAP+1);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int CMP_W   = RUN_W + MW3_W + 4;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run_len;
  logic              run_color;
  logic              close_vld, close_color, close_eol;
  logic [RUN_W-1:0]  close_len;
  logic [RUN_W-1:0]  old_len, prv_len;
  logic              old_color, prv_color, old_vld, prv_vld;
  logic              guard_ok;
  logic [MW3_W-1:0]  guard_sum;
  int                len_a, len_b, len_c;
  logic [CMP_W-1:0]  six_r, s_ext, bound;
  logic [2:0]        units;
  logic              found;
  logic              tok_eol;
  logic [4:0]        token;
  logic              push, lock_load, hist_shift, hist_clear;
  logic [4:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full, pop, do_write;

  function automatic int absdiff(input int x, input int y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  // Pixel pass-through, one cycle late; the delayed active also marks its falling edge.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oPixelSync   <= 1'b0;
      oPixelActive <= 1'b0;
      oPixelData   <= 1'b0;
    end else begin
      oPixelSync   <= iPixelSync;
      oPixelActive <= iPixelActive;
      oPixelData   <= iPixelData;
    end
  end

  // Run counter: count equal active pixels, close on a colour change or when active falls.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      run_len     <= '0;
      run_color   <= 1'b0;
      close_vld   <= 1'b0;
      close_len   <= '0;
      close_color <= 1'b0;
      close_eol   <= 1'b0;
    end else begin
      close_vld <= 1'b0;
      if (iPixelSync) begin
        // Start of line: any run in flight is discarded, not closed.
        run_len   <= iPixelActive ? RUN_W'(1) : '0;
        run_color <= iPixelData;
      end else if (iPixelActive) begin
        if (run_len != '0 && iPixelData != run_color) begin
          close_vld   <= 1'b1;
          close_len   <= run_len;
          close_color <= run_color;
          close_eol   <= 1'b0;
          run_len     <= RUN_W'(1);
          run_color   <= iPixelData;
        end else if (run_len == '0) begin
          run_len   <= RUN_W'(1);
          run_color <= iPixelData;
        end else if (run_len != RUN_W'(RUN_CAP)) begin
          run_len <= run_len + 1'b1;
        end
      end else if (oPixelActive && run_len != '0) begin
        close_vld   <= 1'b1;
        close_len   <= run_len;
        close_color <= run_color;
        close_eol   <= 1'b1;
        run_len     <= '0;
      end
    end
  end

  // Guard test on (older, previous, just-closed) runs: bar-space-bar, widths in range and close together.
  always_comb begin
    len_a = int'(old_len);
    len_b = int'(prv_len);
    len_c = int'(close_len);
    guard_ok = old_vld && prv_vld &&
               (old_color == POLARITY) && (prv_color != POLARITY) && (close_color == POLARITY) &&
               (len_a >= MIN_MODULE_WIDTH) && (len_a <= MAX_MODULE_WIDTH) &&
               (len_b >= MIN_MODULE_WIDTH) && (len_b <= MAX_MODULE_WIDTH) &&
               (len_c >= MIN_MODULE_WIDTH) && (len_c <= MAX_MODULE_WIDTH) &&
               (absdiff(len_a, len_b) <= TOL_MODULE_WIDTH) &&
               (absdiff(len_b, len_c) <= TOL_MODULE_WIDTH) &&
               (absdiff(len_a, len_c) <= TOL_MODULE_WIDTH);
    guard_sum = MW3_W'(len_a + len_b + len_c);
  end

  // Quantise: r/(S/3) rounded to nearest module, i.e. smallest k with 6r < (2k+1)S; 0 when too short or too long.
  always_comb begin
    six_r = CMP_W'(close_len) * CMP_W'(6);
    s_ext = CMP_W'(oModuleWidth3);
    bound = '0;
    units = '0;
    found = 1'b0;
    if (six_r >= s_ext) begin
      for (int k = 1; k <= MAX_UNITS; k++) begin
        bound = CMP_W'(2*k+1) * s_ext;
        if (!found && six_r < bound) begin
          units = 3'(k);
          found = 1'b1;
        end
      end
    end
    tok_eol = close_eol || (units == 3'd0);
    token   = {tok_eol, (close_color == POLARITY), units};
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= SEARCH;
    else       state <= state_nxt;
  end

  // FSM next state: SEARCH feeds the guard window, LOCKED emits one token per closed run.
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    lock_load  = 1'b0;
    hist_shift = 1'b0;
    hist_clear = 1'b0;
    if (iPixelSync) begin
      state_nxt  = SEARCH;
      hist_clear = 1'b1;
    end else if (close_vld) begin
      unique case (state)
        SEARCH: begin
          hist_shift = 1'b1;
          if (guard_ok) begin
            state_nxt  = LOCKED;
            lock_load  = 1'b1;
            hist_clear = 1'b1;
          end
        end
        LOCKED: begin
          push = 1'b1;
          if (tok_eol) begin
            state_nxt  = SEARCH;
            hist_clear = 1'b1;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  assign oLocked = (state == LOCKED);

  // Guard history: the two runs closed before the current one.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      old_len <= '0; old_color <= 1'b0; old_vld <= 1'b0;
      prv_len <= '0; prv_color <= 1'b0; prv_vld <= 1'b0;
    end else if (hist_clear) begin
      old_vld <= 1'b0;
      prv_vld <= 1'b0;
    end else if (hist_shift) begin
      old_len <= prv_len; old_color <= prv_color; old_vld <= prv_vld;
      prv_len <= close_len; prv_color <= close_color; prv_vld <= 1'b1;
    end
  end

  // Latched guard sum; held across the return to SEARCH so the last lock stays visible.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)          oModuleWidth3 <= '0;
    else if (lock_load) oModuleWidth3 <= guard_sum;
  end

  assign full     = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign pop      = run.oRunValid && run.iRunReady;
  assign do_write = push && (!full || pop);

  assign run.oRunValid = (count != '0);
  assign run.oRunData  = run.oRunValid ? mem[rd_ptr] : 5'd0;

  // FIFO pointers and occupancy.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the read side is masked by occupancy.
  always_ff @(posedge iClk) begin
    if (do_write) mem[wr_ptr] <= token;
  end

  // Sticky drop flag, cleared only at start of line.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                       oOverflow <= 1'b0;
    else if (iPixelSync)             oOverflow <= 1'b0;
    else if (push && full && !pop)   oOverflow <= 1'b1;
  end

endmodule

// File: doc/scanner_run_length.md
SCANNER_RUN_LENGTH -- requirements
Module: scanner_run_length

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 max active pixels per line; MIN_MODULE_WIDTH 2, MAX_MODULE_WIDTH 8, TOL_MODULE_WIDTH 1 guard-run width limits and tolerance in pixels; MAX_UNITS 4 widest accepted run in modules (range 4..7); FIFO_DEPTH 8 token FIFO entries (power of two, >=2); POLARITY 1 pixel value that is a bar.
REQ-002 Ports (name, direction, width, meaning): iClk in 1 clock; iRst in 1 reset, asynchronous, active-low; iPixelSync in 1 start-of-line pulse; iPixelActive in 1 pixel valid; iPixelData in 1 binarised pixel; oPixelSync/oPixelActive/oPixelData out 1 each, inputs delayed one cycle; oRunData out 5 token {eol, color, units[2:0]}; oRunValid out 1; iRunReady in 1; oModuleWidth3 out clog2(3*MAX_MODULE_WIDTH+1) locked guard sum; oLocked out 1; oOverflow out 1.

Function
REQ-003 Run counter SHALL count consecutive active pixels of equal value, saturating at RUN_MAX = MAX_MODULE_WIDTH*MAX_UNITS+TOL_MODULE_WIDTH; inactive pixels SHALL neither count nor close a run.
REQ-004 A run SHALL close on the first active pixel of opposite value, or on the cycle iPixelActive falls (end of line).
REQ-005 FSM SHALL have states SEARCH and LOCKED; reset and iPixelSync enter SEARCH and clear run counter and guard history.
REQ-006 In SEARCH, the last three closed runs SHALL be kept; on closure of a bar run, if the three are bar,space,bar, each within [MIN_MODULE_WIDTH, MAX_MODULE_WIDTH], and pairwise difference <= TOL_MODULE_WIDTH, FSM SHALL enter LOCKED and latch S = sum of the three into oModuleWidth3.
REQ-007 Guard runs SHALL NOT be emitted as tokens; SEARCH SHALL emit no tokens.
REQ-008 In LOCKED, each closed run of length r SHALL produce one token: units = smallest k in 1..MAX_UNITS with 6r < (2k+1)*S; units = 0 if 6r < S or no k qualifies.
REQ-009 color = 1 for bar run, 0 for space run; eol = 1 when closure is end of line or units = 0.
REQ-010 A token with eol = 1 SHALL return FSM to SEARCH, clear oLocked, hold oModuleWidth3.
REQ-011 oLocked SHALL equal (state == LOCKED).
REQ-012 Latency: closing pixel sampled at edge N, token written to FIFO at edge N+1, oRunValid high from edge N+1 if FIFO was empty.
REQ-013 FIFO SHALL be first-word-fall-through; oRunData valid whenever oRunValid = 1; pop on oRunValid && iRunReady; oRunData SHALL hold stable while oRunValid && !iRunReady.
REQ-014 Push when full and no pop SHALL drop the token and set oOverflow; push and pop in the same cycle when full SHALL both succeed.
REQ-015 oOverflow SHALL be sticky until iPixelSync or reset; iPixelSync SHALL NOT flush the FIFO.
REQ-016 iPixelSync coincident with a run closure SHALL discard that closure (no token).
REQ-017 Token order in FIFO SHALL equal run order on the line.

Reset
REQ-018 iRst low SHALL immediately force: FIFO empty, oRunValid 0, oRunData 0, oLocked 0, oOverflow 0, oModuleWidth3 0, pass-through outputs 0, FSM SEARCH, run counter 0.
REQ-019 Reset asserted mid-line SHALL discard partial run and pending tokens; first token after release requires a new guard.

Verification (MIN 4, MAX 8, TOL 1, FIFO_DEPTH 4, POLARITY 1)
REQ-020 Line: space 10, bar 5, space 5, bar 5, space 10, bar 15, active falls -> oLocked rises after second bar, oModuleWidth3 = 15, tokens 5'b00010 then 5'b11011, oLocked 0 after eol.
REQ-021 Line: bar 5, space 7, bar 5, space 10 -> no lock, oRunValid never asserts.
REQ-022 Locked with S = 15, then space 40 -> single token 5'b10000, FSM to SEARCH, oLocked 0.
REQ-023 iRunReady = 0, six tokens generated -> four stored, oOverflow = 1; iRunReady = 1 -> four tokens in line order, oRunValid falls; next iPixelSync clears oOverflow.
REQ-024 Locked with two tokens queued, iRst low one cycle -> all outputs 0 in that cycle without clock edge; no tokens after release until new guard.
